// File: rtl/bsg_link_sched_pkg.sv
// bsg_link_sched_pkg: shared FSM state type and credit-width helper for the upstream scheduler.
package bsg_link_sched_pkg;

    typedef enum logic [1:0] {S_RESET, S_INIT, S_RUN} state_e;

    function automatic int credit_width(input int credit_max);
        return $clog2(credit_max + 1);
    endfunction

endpackage

// File: rtl/bsg_rr_arbiter_comb.sv
// bsg_rr_arbiter_comb: combinational round-robin arbiter.
// Ports: req (request vector), ptr (highest-priority index),
//        grant (one-hot winner), id (encoded winner), any (some request present).
module bsg_rr_arbiter_comb #(
    parameter int num_req_p = 4
) (
    input  logic [num_req_p-1:0]         req,
    input  logic [$clog2(num_req_p)-1:0] ptr,
    output logic [num_req_p-1:0]         grant,
    output logic [$clog2(num_req_p)-1:0] id,
    output logic                         any
);
    import bsg_link_sched_pkg::*;

    localparam int id_w = $clog2(num_req_p);

    logic found;
    int   j;

    assign any = |req;

    // Walk upward from ptr with wrap; the first active request wins.
    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < num_req_p; k++) begin
            j = (int'(ptr) + k) % num_req_p;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                id       = id_w'(j);
            end
        end
    end

endmodule

// File: rtl/bsg_link_upstream_scheduler.sv
// bsg_link_upstream_scheduler: credit-aware round-robin mux of core requesters onto one link port,
// with link bring-up sequencing (reset hold, then credit init).
// Ports: clk/rst; req_valid_i/req_data_i/req_ready_o (requesters); link_reset_o, link_valid_o,
//        link_data_o, link_ready_i (link core side); token_i (credit return); credits_o,
//        grant_id_o, overflow_o (status).
module bsg_link_upstream_scheduler #(
    parameter int num_req_p          = 4,
    parameter int width_p            = 64,
    parameter int credit_max_p       = 16,
    parameter int token_decimation_p = 4,
    parameter int reset_cycles_p     = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [num_req_p-1:0]                  req_valid_i,
    input  logic [num_req_p*width_p-1:0]          req_data_i,
    output logic [num_req_p-1:0]                  req_ready_o,
    output logic                                  link_reset_o,
    output logic                                  link_valid_o,
    output logic [width_p-1:0]                    link_data_o,
    input  logic                                  link_ready_i,
    input  logic                                  token_i,
    output logic [$clog2(credit_max_p+1)-1:0]     credits_o,
    output logic [$clog2(num_req_p)-1:0]          grant_id_o,
    output logic                                  overflow_o
);
    import bsg_link_sched_pkg::*;

    localparam int cw   = credit_width(credit_max_p);
    localparam int id_w = $clog2(num_req_p);
    localparam int hw   = $clog2(reset_cycles_p + 1);

    state_e            state, state_n;
    logic [hw-1:0]     hold;
    logic [id_w-1:0]   ptr;
    logic [num_req_p-1:0] grant;
    logic [id_w-1:0]   win;
    logic              any;
    logic              run;
    logic              fire;
    logic [cw:0]       sum;

    bsg_rr_arbiter_comb #(.num_req_p(num_req_p)) arb (
        .req   (req_valid_i),
        .ptr   (ptr),
        .grant (grant),
        .id    (win),
        .any   (any)
    );

    assign run          = state == S_RUN;
    assign link_reset_o = state == S_RESET;
    assign link_valid_o = run && any && credits_o != '0;
    assign fire         = link_valid_o && link_ready_i;
    assign link_data_o  = link_valid_o ? req_data_i[win*width_p +: width_p] : '0;
    assign grant_id_o   = link_valid_o ? win : '0;
    assign req_ready_o  = fire ? grant : '0;

    // One bit wider than credits so an over-return is detectable before clamping.
    always_comb begin
        state_n = state == S_RESET ? (hold == hw'(reset_cycles_p - 1) ? S_INIT : S_RESET) : S_RUN;
        sum     = (cw+1)'(credits_o) - (cw+1)'(fire) + (token_i ? (cw+1)'(token_decimation_p) : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_RESET;
            hold       <= '0;
            credits_o  <= '0;
            ptr        <= '0;
            overflow_o <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_RESET)
                hold <= hold + 1'b1;
            if (state == S_INIT)
                credits_o <= cw'(credit_max_p);
            else if (run) begin
                credits_o <= sum > (cw+1)'(credit_max_p) ? cw'(credit_max_p) : sum[cw-1:0];
                if (sum > (cw+1)'(credit_max_p))
                    overflow_o <= 1'b1;
            end
            if (fire)
                ptr <= id_w'((int'(win) + 1) % num_req_p);
        end
    end

endmodule

// File: tb/tb_bsg_link_upstream_scheduler.sv
// tb_bsg_link_upstream_scheduler: randomized stimulus checked each cycle against a behavioural model.
module tb_bsg_link_upstream_scheduler;
    localparam int N   = 4;
    localparam int W   = 64;
    localparam int MAX = 16;
    localparam int DEC = 4;
    localparam int RC  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           link_reset;
    logic           link_valid;
    logic [W-1:0]   link_data;
    logic           link_ready;
    logic           token;
    logic [4:0]     credits;
    logic [1:0]     grant_id;
    logic           overflow;

    int n_tests = 0;
    int n_fail  = 0;

    int m_age, m_cred, m_ptr, m_ovf;

    bsg_link_upstream_scheduler #(
        .num_req_p(N), .width_p(W), .credit_max_p(MAX),
        .token_decimation_p(DEC), .reset_cycles_p(RC)
    ) dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(req_ready), .link_reset_o(link_reset), .link_valid_o(link_valid),
        .link_data_o(link_data), .link_ready_i(link_ready), .token_i(token),
        .credits_o(credits), .grant_id_o(grant_id), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int winner();
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    initial begin
        int w, phase, tok_div;
        logic ev;
        rst = 1'b1; req_valid = '0; req_data = '0; link_ready = 1'b0; token = 1'b0;
        repeat (2) @(posedge clk);
        m_age = 0; m_cred = 0; m_ptr = 0; m_ovf = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            phase   = (cyc / 250) % 4;
            tok_div = phase == 0 ? 40 : phase == 1 ? 3 : phase == 2 ? 12 : 2;
            rst        = cyc > 20 && $urandom_range(0, 599) == 0;
            token      = $urandom_range(0, tok_div - 1) == 0;
            link_ready = phase == 2 ? $urandom_range(0, 1) == 0 : $urandom_range(0, 4) != 0;
            req_valid  = N'($urandom);
            if (phase == 0 && $urandom_range(0, 3) != 0) req_valid = 4'b0100;
            for (int i = 0; i < N; i++) req_data[i*W +: W] = {$urandom, $urandom};
            #1;
            w  = winner();
            ev = m_age > RC && w >= 0 && m_cred != 0;
            chk("link_reset", 64'(link_reset), 64'(m_age < RC));
            chk("link_valid", 64'(link_valid), 64'(ev));
            chk("link_data", link_data, ev ? req_data[w*W +: W] : 64'd0);
            chk("grant_id", 64'(grant_id), ev ? 64'(w) : 64'd0);
            chk("req_ready", 64'(req_ready), (ev && link_ready) ? 64'(1) << w : 64'd0);
            chk("credits", 64'(credits), 64'(m_cred));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            @(posedge clk);
            if (rst) begin
                m_age = 0; m_cred = 0; m_ptr = 0; m_ovf = 0;
            end else begin
                if (m_age == RC) m_cred = MAX;
                else if (m_age > RC) begin
                    m_cred = m_cred - int'(ev && link_ready) + (token ? DEC : 0);
                    if (m_cred > MAX) begin
                        m_cred = MAX;
                        m_ovf  = 1;
                    end
                    if (ev && link_ready) m_ptr = (w + 1) % N;
                end
                if (m_age <= RC) m_age++;
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
